frame_hold_timer: RTL and testbench

- Frame-based hold/release timer; the turn-off counterpart of the frame-delayed turn-on used for monsters.
- A trigger asserts `active` immediately and holds it for a fixed number of frames, blinking a `visible` flag at a frame rate.
- It then runs a cooldown during which new triggers are ignored.
- Used for player/monster hit-invulnerability flashing and weapon cooldowns, clocked per frame by startOfFrame.

---
 rtl/frame_hold_timer_pkg.sv | 17 +
 rtl/frame_down_counter.sv | 29 ++
 rtl/frame_hold_timer.sv | 139 +++++++++++++
 tb/tb_frame_hold_timer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_hold_timer_pkg.sv
// Shared definitions for the frame hold/release timer: counter width and FSM states.
package frame_hold_timer_pkg;

  localparam int FRAME_TIMER_WIDTH = 8;

  typedef enum logic [1:0] {
    FHT_IDLE     = 2'd0,
    FHT_ACTIVE   = 2'd1,
    FHT_COOLDOWN = 2'd2
  } fht_state_t;

  // Truncate an integer frame count to the counter width.
  function automatic logic [FRAME_TIMER_WIDTH-1:0] to_frames(input int unsigned n);
    return n[FRAME_TIMER_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable per-frame down counter that saturates at zero; used for the phase and blink timers.
module frame_down_counter
  import frame_hold_timer_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         load,
  input  logic [FRAME_TIMER_WIDTH-1:0] load_value,
  input  logic                         startOfFrame,
  output logic [FRAME_TIMER_WIDTH-1:0] count,
  output logic                         at_one
);

  localparam logic [FRAME_TIMER_WIDTH-1:0] ONE = FRAME_TIMER_WIDTH'(1);

  // Load wins over a same-cycle tick; zero is held rather than wrapped.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (startOfFrame && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign at_one = (count == ONE);

endmodule

// File: rtl/frame_hold_timer.sv
// Trigger-started hold timer with blinking visibility and a cooldown that ignores new triggers.
module frame_hold_timer
  import frame_hold_timer_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES     = 60,
  parameter int unsigned BLINK_FRAMES    = 4,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter logic        RETRIGGER_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         trigger,
  output logic                         active,
  output logic                         visible,
  output logic                         busy,
  output logic                         done_pulse,
  output logic [FRAME_TIMER_WIDTH-1:0] frames_left,
  output logic [1:0]                   state_dbg
);

  localparam logic [FRAME_TIMER_WIDTH-1:0] HOLD_V  = to_frames(HOLD_FRAMES);
  localparam logic [FRAME_TIMER_WIDTH-1:0] BLINK_V = to_frames(BLINK_FRAMES);
  localparam logic [FRAME_TIMER_WIDTH-1:0] COOL_V  = to_frames(COOLDOWN_FRAMES);
  localparam logic                         BLINK_ON = (BLINK_FRAMES != 0);

  fht_state_t state, next_state;

  logic [FRAME_TIMER_WIDTH-1:0] phase_count, blink_count;
  logic [FRAME_TIMER_WIDTH-1:0] phase_load_value;
  logic phase_at_one, blink_at_one;
  logic phase_load, phase_tick;
  logic entry, retrig, hold_end, cool_end;
  logic blink_tick, blink_toggle;
  logic active_d, visible_d, busy_d, done_d;

  // Retrigger outranks a same-cycle frame tick, so it suppresses the exit.
  assign entry        = (state == FHT_IDLE) && trigger;
  assign retrig       = (state == FHT_ACTIVE) && RETRIGGER_EN && trigger;
  assign hold_end     = (state == FHT_ACTIVE) && !retrig && startOfFrame && phase_at_one;
  assign cool_end     = (state == FHT_COOLDOWN) && startOfFrame && phase_at_one;
  assign blink_tick   = BLINK_ON && (state == FHT_ACTIVE) && startOfFrame && !hold_end;
  assign blink_toggle = blink_tick && blink_at_one;

  assign phase_load = entry || retrig || hold_end || cool_end;
  assign phase_tick = startOfFrame && (state != FHT_IDLE);

  always_comb begin
    phase_load_value = '0;
    if (entry || retrig) begin
      phase_load_value = HOLD_V;
    end else if (hold_end) begin
      phase_load_value = COOL_V;
    end
  end

  frame_down_counter u_phase_counter (
    .clk          (clk),
    .resetN       (resetN),
    .load         (phase_load),
    .load_value   (phase_load_value),
    .startOfFrame (phase_tick),
    .count        (phase_count),
    .at_one       (phase_at_one)
  );

  frame_down_counter u_blink_counter (
    .clk          (clk),
    .resetN       (resetN),
    .load         (entry || blink_toggle),
    .load_value   (BLINK_V),
    .startOfFrame (blink_tick),
    .count        (blink_count),
    .at_one       (blink_at_one)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= FHT_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      FHT_IDLE: begin
        if (entry) next_state = FHT_ACTIVE;
      end
      FHT_ACTIVE: begin
        if (hold_end) next_state = (COOL_V == '0) ? FHT_IDLE : FHT_COOLDOWN;
      end
      FHT_COOLDOWN: begin
        if (cool_end) next_state = FHT_IDLE;
      end
      default: next_state = FHT_IDLE;
    endcase
  end

  // Output values for the next cycle; registered below so every output is a flop.
  always_comb begin
    active_d  = (next_state == FHT_ACTIVE);
    busy_d    = (next_state != FHT_IDLE);
    done_d    = (state == FHT_ACTIVE) && (next_state != FHT_ACTIVE);
    visible_d = 1'b1;
    if (next_state == FHT_ACTIVE) begin
      if (state != FHT_ACTIVE) begin
        visible_d = 1'b0;
      end else if (blink_toggle) begin
        visible_d = !visible;
      end else begin
        visible_d = visible;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active     <= 1'b0;
      visible    <= 1'b1;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      active     <= active_d;
      visible    <= visible_d;
      busy       <= busy_d;
      done_pulse <= done_d;
    end
  end

  assign frames_left = phase_count;
  assign state_dbg   = state;

  // blink_count is only observed through at_one; keep it visible for probing.
  logic [FRAME_TIMER_WIDTH-1:0] blink_count_probe;
  assign blink_count_probe = blink_count;

endmodule

// File: tb/tb_frame_hold_timer.sv
// Bench for frame_hold_timer: five parameterisations share one stimulus stream and one frame-count model.
module tb_frame_hold_timer;
  import frame_hold_timer_pkg::*;

  localparam int N = 5;
  localparam int HP [N] = '{60, 3, 8, 4, 4};
  localparam int BP [N] = '{4, 0, 2, 4, 4};
  localparam int CP [N] = '{30, 2, 0, 3, 3};
  localparam int RP [N] = '{1, 1, 0, 1, 0};

  logic clk, resetN, startOfFrame, trigger;
  logic act [N];
  logic vis [N];
  logic bsy [N];
  logic dn  [N];
  logic [FRAME_TIMER_WIDTH-1:0] fl [N];
  logic [1:0] dbg [N];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    frame_hold_timer #(
      .HOLD_FRAMES     (HP[g]),
      .BLINK_FRAMES    (BP[g]),
      .COOLDOWN_FRAMES (CP[g]),
      .RETRIGGER_EN    (RP[g] != 0)
    ) u_dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .trigger      (trigger),
      .active       (act[g]),
      .visible      (vis[g]),
      .busy         (bsy[g]),
      .done_pulse   (dn[g]),
      .frames_left  (fl[g]),
      .state_dbg    (dbg[g])
    );
  end

  // ---------------- reference model ----------------
  // Tracks remaining hold/cooldown frames and how many frame ticks the blink has seen.
  int  m_hold  [N];
  int  m_cool  [N];
  int  m_ticks [N];
  bit  m_done  [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hold[i] = 0; m_cool[i] = 0; m_ticks[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step(input bit t, input bit s);
    for (int i = 0; i < N; i++) begin
      m_done[i] = 0;
      if (m_hold[i] > 0) begin
        if (RP[i] != 0 && t) begin
          m_hold[i] = HP[i];
          if (s) m_ticks[i]++;
        end else if (s) begin
          if (m_hold[i] == 1) begin
            m_hold[i] = 0; m_done[i] = 1; m_cool[i] = CP[i];
          end else begin
            m_hold[i]--; m_ticks[i]++;
          end
        end
      end else if (m_cool[i] > 0) begin
        if (s) m_cool[i]--;
      end else if (t) begin
        m_hold[i] = HP[i]; m_ticks[i] = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] at %0t: got %0d expected %0d", name, idx, $time, got, exp);
    end
  endtask

  task automatic check_all();
    int e_act, e_busy, e_vis, e_fl;
    for (int i = 0; i < N; i++) begin
      e_act  = (m_hold[i] > 0) ? 1 : 0;
      e_busy = (m_hold[i] > 0 || m_cool[i] > 0) ? 1 : 0;
      e_fl   = (m_hold[i] > 0) ? m_hold[i] : m_cool[i];
      if (e_act == 0)      e_vis = 1;
      else if (BP[i] == 0) e_vis = 0;
      else                 e_vis = ((m_ticks[i] / BP[i]) % 2 == 1) ? 1 : 0;
      chk("active", i, int'(act[i]), e_act);
      chk("busy", i, int'(bsy[i]), e_busy);
      chk("visible", i, int'(vis[i]), e_vis);
      chk("done_pulse", i, int'(dn[i]), int'(m_done[i]));
      chk("frames_left", i, int'(fl[i]), e_fl);
      chk("state_busy", i, (dbg[i] != 2'd0) ? 1 : 0, e_busy);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives inputs, advances one clock, compares at posedge+1.
  task automatic cycle(input bit t, input bit s);
    trigger = t;
    startOfFrame = s;
    @(posedge clk);
    if (resetN) model_step(t, s);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    resetN = 1'b0; trigger = 1'b0; startOfFrame = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    resetN = 1'b1;
  endtask

  typedef struct {
    bit t; bit s;
    bit e_act; bit e_vis; bit e_busy; bit e_done; int e_fl;
  } vec_t;

  vec_t tbl [9];
  bit pat [8];

  initial begin
    int k;
    bit found;
    int hold_cnt;
    bit t, s;

    resetN = 1'b0; trigger = 1'b0; startOfFrame = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    resetN = 1'b1;

    // Idle: frame pulses alone do nothing.
    for (int f = 0; f < 5; f++) begin
      cycle(0, 1);
      cycle(0, 0);
    end
    chk("idle_active", 0, int'(act[0]), 0);
    chk("idle_visible", 0, int'(vis[0]), 1);
    chk("idle_frames_left", 0, int'(fl[0]), 0);

    // Table: u1 (HOLD=3, BLINK=0, COOLDOWN=2), trigger ignored in cooldown.
    tbl[0] = '{1, 0, 1, 0, 1, 0, 3};
    tbl[1] = '{0, 1, 1, 0, 1, 0, 2};
    tbl[2] = '{0, 0, 1, 0, 1, 0, 2};
    tbl[3] = '{0, 1, 1, 0, 1, 0, 1};
    tbl[4] = '{0, 1, 0, 1, 1, 1, 2};
    tbl[5] = '{1, 0, 0, 1, 1, 0, 2};
    tbl[6] = '{0, 1, 0, 1, 1, 0, 1};
    tbl[7] = '{0, 1, 0, 1, 0, 0, 0};
    tbl[8] = '{0, 1, 0, 1, 0, 0, 0};
    do_reset();
    for (int v = 0; v < 9; v++) begin
      cycle(tbl[v].t, tbl[v].s);
      chk("tbl_active", 1, int'(act[1]), int'(tbl[v].e_act));
      chk("tbl_visible", 1, int'(vis[1]), int'(tbl[v].e_vis));
      chk("tbl_busy", 1, int'(bsy[1]), int'(tbl[v].e_busy));
      chk("tbl_done", 1, int'(dn[1]), int'(tbl[v].e_done));
      chk("tbl_frames_left", 1, int'(fl[1]), tbl[v].e_fl);
    end

    // Blink pattern: u2 (HOLD=8, BLINK=2, COOLDOWN=0).
    pat = '{0, 0, 1, 1, 0, 0, 1, 1};
    do_reset();
    cycle(1, 0);
    for (int f = 0; f < 8; f++) begin
      chk("blink_pattern", 2, int'(vis[2]), int'(pat[f]));
      cycle(0, 1);
    end
    chk("blink_exit_visible", 2, int'(vis[2]), 1);
    chk("blink_exit_done", 2, int'(dn[2]), 1);
    chk("no_cooldown_busy", 2, int'(bsy[2]), 0);

    // Retrigger on 3rd frame: u3 reloads, u4 (no retrigger) keeps counting.
    do_reset();
    cycle(1, 0);
    cycle(0, 1);
    cycle(0, 1);
    cycle(1, 1);
    chk("retrig_reload", 3, int'(fl[3]), 4);
    chk("no_retrig_count", 4, int'(fl[4]), 1);
    cycle(0, 1);
    chk("no_retrig_done", 4, int'(dn[4]), 1);
    cycle(0, 1);
    cycle(0, 1);
    chk("retrig_last_frame", 3, int'(fl[3]), 1);
    cycle(0, 1);
    chk("retrig_done", 3, int'(dn[3]), 1);
    chk("retrig_inactive", 3, int'(act[3]), 0);

    // Trigger held through the cooldown end re-enters one clock after busy drops (u4).
    do_reset();
    found = 0;
    for (k = 0; k < 100; k++) begin
      cycle(1, k[0]);
      if (!bsy[4]) begin
        found = 1;
        break;
      end
    end
    chk("cooldown_end_seen", 4, int'(found), 1);
    chk("idle_gap_active", 4, int'(act[4]), 0);
    cycle(1, 0);
    chk("reentry_active", 4, int'(act[4]), 1);
    chk("reentry_frames_left", 4, int'(fl[4]), 4);

    // Asynchronous reset with u1 at frames_left=2.
    do_reset();
    cycle(1, 0);
    cycle(0, 1);
    chk("pre_reset_frames_left", 1, int'(fl[1]), 2);
    #2;
    resetN = 1'b0; trigger = 1'b0; startOfFrame = 1'b0;
    #1;
    model_reset();
    chk("async_rst_active", 1, int'(act[1]), 0);
    chk("async_rst_visible", 1, int'(vis[1]), 1);
    chk("async_rst_frames_left", 1, int'(fl[1]), 0);
    check_all();
    @(posedge clk);
    #1;
    chk("async_rst_no_done", 1, int'(dn[1]), 0);
    check_all();
    resetN = 1'b1;

    // Random stimulus against the model.
    hold_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        if (hold_cnt > 0) begin
          t = 1; hold_cnt--;
        end else if ($urandom_range(0, 30) == 0) begin
          t = 1; hold_cnt = $urandom_range(0, 40);
        end else begin
          t = 0;
        end
        s = ($urandom_range(0, 3) == 0);
        cycle(t, s);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
